// File: rtl/usb_fs_rx_monitor.sv
// usb_fs_rx_monitor: host-side full-speed USB receive monitor.
// Pipeline: 2-flop sync -> DPLL bit recovery -> SYNC detect -> NRZI decode
// -> bit unstuff -> byte assemble -> EOP check.
// Optional CRC5/CRC16 checking is built when USB_RX_MON_CRC_EN is defined;
// otherwise rx_err_crc is tied low and no CRC logic exists.
module usb_fs_rx_monitor #(
  parameter int SAMPLES_PER_BIT = 4,
  parameter int CNT_W           = 11
) (
  input  logic             clk48_host,
  input  logic             reset_n,
  input  logic             usb_d_p,
  input  logic             usb_d_n,
  input  logic             enable,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_pkt_start,
  output logic             rx_pkt_end,
  output logic             rx_err_stuff,
  output logic             rx_err_align,
  output logic             rx_err_crc,
  output logic             rx_active,
  output logic [CNT_W-1:0] rx_byte_cnt
);
  localparam int PH_W      = $clog2(SAMPLES_PER_BIT);
  localparam int SAMPLE_PH = SAMPLES_PER_BIT / 2;

  // Line states as {D+, D-}
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  // SYNC pattern KJKJKJKK, bit i set where sample i must be K
  localparam logic [7:0] SYNC_K = 8'hD5;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ABORT} state_t;

  logic [1:0]       rst_ff;
  logic             rst_n;
  logic [1:0]       dp_s, dn_s;
  logic [1:0]       ls, ls_q;
  logic [PH_W-1:0]  phase_q, phase_cur;
  logic             smp;

  state_t           state;
  logic [2:0]       sync_idx;
  logic [1:0]       prev_ls;
  logic [2:0]       ones;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             eop_2nd;
  logic [2:0]       j_cnt;

  logic             run, is_jk, nrzi_bit, match_sync;
  logic             sync_ok, stuff_err, data_bit, byte_done, eop_ok;
  logic [7:0]       byte_nxt;

  // Reset: asynchronous assert, deassert released through two flops
  always_ff @(posedge clk48_host or negedge reset_n) begin
    if (!reset_n) rst_ff <= 2'b00;
    else          rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  // Bring D+/D- into the clock domain; keep last line state for edge detect
  always_ff @(posedge clk48_host or negedge rst_n) begin
    if (!rst_n) begin
      dp_s <= 2'b00;
      dn_s <= 2'b00;
      ls_q <= LS_SE0;
    end else begin
      dp_s <= {dp_s[0], usb_d_p};
      dn_s <= {dn_s[0], usb_d_n};
      ls_q <= ls;
    end
  end
  assign ls = {dp_s[1], dn_s[1]};

  // DPLL: any line change realigns the bit phase; sample mid-bit
  assign phase_cur = (ls != ls_q) ? '0 : phase_q;
  assign smp       = (phase_cur == PH_W'(SAMPLE_PH));

  // Phase counter free-runs mod SAMPLES_PER_BIT between edges
  always_ff @(posedge clk48_host or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_cur + PH_W'(1);
  end

  assign run        = enable && smp;
  assign is_jk      = (ls == LS_J) || (ls == LS_K);
  assign nrzi_bit   = (ls == prev_ls);
  assign match_sync = (ls == (SYNC_K[sync_idx] ? LS_K : LS_J));
  assign sync_ok    = run && (state == S_SYNC) && match_sync && (sync_idx == 3'd7);
  // SE1, or a 1 where the stuffed 0 should be, kills the packet
  assign stuff_err  = run && (state == S_DATA) &&
                      ((ls == LS_SE1) || (is_jk && (ones == 3'd6) && nrzi_bit));
  // A J/K sample that is not the stuffed 0 carries payload
  assign data_bit   = run && (state == S_DATA) && is_jk && (ones != 3'd6);
  assign byte_done  = data_bit && (bit_cnt == 3'd7);
  assign byte_nxt   = {nrzi_bit, shreg[7:1]};
  assign eop_ok     = run && (state == S_EOP) && eop_2nd && (ls == LS_J);

  // Packet FSM with registered strobes
  always_ff @(posedge clk48_host or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sync_idx     <= 3'd0;
      prev_ls      <= LS_SE0;
      ones         <= 3'd0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      eop_2nd      <= 1'b0;
      j_cnt        <= 3'd0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_pkt_start <= 1'b0;
      rx_pkt_end   <= 1'b0;
      rx_err_stuff <= 1'b0;
      rx_err_align <= 1'b0;
      rx_active    <= 1'b0;
      rx_byte_cnt  <= '0;
    end else begin
      rx_valid     <= 1'b0;
      rx_pkt_start <= 1'b0;
      rx_pkt_end   <= 1'b0;
      rx_err_stuff <= 1'b0;
      rx_err_align <= 1'b0;
      if (!enable) begin
        state     <= S_IDLE;
        rx_active <= 1'b0;
      end else if (smp) begin
        case (state)
          S_IDLE: begin
            if (ls == LS_K) begin
              state    <= S_SYNC;
              sync_idx <= 3'd1;
            end
          end
          S_SYNC: begin
            if (sync_ok) begin
              state        <= S_DATA;
              rx_pkt_start <= 1'b1;
              rx_active    <= 1'b1;
              rx_byte_cnt  <= '0;
              prev_ls      <= LS_K;
              ones         <= 3'd0;
              bit_cnt      <= 3'd0;
            end else if (match_sync) begin
              sync_idx <= sync_idx + 3'd1;
            end else begin
              state <= S_IDLE;
            end
          end
          S_DATA: begin
            if (ls == LS_SE0) begin
              state   <= S_EOP;
              eop_2nd <= 1'b0;
            end else if (stuff_err) begin
              rx_err_stuff <= 1'b1;
              rx_active    <= 1'b0;
              j_cnt        <= 3'd0;
              state        <= S_ABORT;
            end else begin
              prev_ls <= ls;
              if (data_bit) begin
                ones    <= nrzi_bit ? ones + 3'd1 : 3'd0;
                shreg   <= byte_nxt;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                  rx_valid <= 1'b1;
                  rx_data  <= byte_nxt;
                  if (rx_byte_cnt != {CNT_W{1'b1}})
                    rx_byte_cnt <= rx_byte_cnt + CNT_W'(1);
                end
              end else begin
                ones <= 3'd0;  // stuffed zero, dropped
              end
            end
          end
          S_EOP: begin
            if (eop_ok) begin
              rx_pkt_end   <= 1'b1;
              rx_err_align <= (bit_cnt != 3'd0);
              rx_active    <= 1'b0;
              state        <= S_IDLE;
            end else if (!eop_2nd && (ls == LS_SE0)) begin
              eop_2nd <= 1'b1;
            end else begin
              rx_active <= 1'b0;
              j_cnt     <= 3'd0;
              state     <= S_ABORT;
            end
          end
          S_ABORT: begin
            if (ls == LS_J) begin
              if (j_cnt == 3'd7) state <= S_IDLE;
              else               j_cnt <= j_cnt + 3'd1;
            end else begin
              j_cnt <= 3'd0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef USB_RX_MON_CRC_EN
  logic [15:0] crc16;
  logic [4:0]  crc5;
  logic [7:0]  pid;
  logic        pid_done;
  logic        crc_bad;

  always_comb begin
    crc_bad = 1'b0;
    case (pid[3:0])
      4'h3, 4'hB, 4'h7, 4'hF: crc_bad = (crc16 != 16'h800D);
      4'h1, 4'h9, 4'h5, 4'hD: crc_bad = (crc5 != 5'h0C);
      default:                crc_bad = 1'b0;
    endcase
  end

  // CRC over unstuffed bits after the PID; checked against residual at EOP
  always_ff @(posedge clk48_host or negedge rst_n) begin
    if (!rst_n) begin
      crc16      <= 16'hFFFF;
      crc5       <= 5'h1F;
      pid        <= 8'h00;
      pid_done   <= 1'b0;
      rx_err_crc <= 1'b0;
    end else begin
      rx_err_crc <= 1'b0;
      if (sync_ok) begin
        crc16    <= 16'hFFFF;
        crc5     <= 5'h1F;
        pid_done <= 1'b0;
      end else if (data_bit) begin
        if (pid_done) begin
          crc16 <= {crc16[14:0], 1'b0} ^ ((nrzi_bit ^ crc16[15]) ? 16'h8005 : 16'h0000);
          crc5  <= {crc5[3:0], 1'b0} ^ ((nrzi_bit ^ crc5[4]) ? 5'h05 : 5'h00);
        end else if (bit_cnt == 3'd7) begin
          pid_done <= 1'b1;
          pid      <= byte_nxt;
        end
      end
      if (eop_ok) rx_err_crc <= pid_done && crc_bad;
    end
  end
`else
  assign rx_err_crc = 1'b0;
`endif

endmodule

// File: tb/tb_usb_fs_rx_monitor.sv
// tb_usb_fs_rx_monitor: directed packets, expected events queued at drive time
// and popped by a monitor as the DUT emits strobes.
module tb_usb_fs_rx_monitor;
  localparam int CNT_W = 11;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
  localparam int JIT [8] = '{5, 3, 4, 5, 3, 4, 5, 4};
  // Event word: {start, valid, end, stuff, align, crc, data}
  localparam logic [13:0] EV_START = {6'b100000, 8'h00};
  localparam logic [13:0] EV_STUFF = {6'b000100, 8'h00};
  localparam int NOSTUFF_OFF = 1 << 20;

  logic             clk48_host = 1'b0;
  logic             reset_n = 1'b1;
  logic             usb_d_p = 1'b1;
  logic             usb_d_n = 1'b0;
  logic             enable = 1'b1;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_pkt_start, rx_pkt_end, rx_err_stuff;
  logic             rx_err_align, rx_err_crc, rx_active;
  logic [CNT_W-1:0] rx_byte_cnt;
  logic [25:0]      outs;

  int          checks = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];
  bit          bq[$];
  logic [1:0]  lq[$];

  usb_fs_rx_monitor #(.SAMPLES_PER_BIT(4), .CNT_W(CNT_W)) dut (
    .clk48_host(clk48_host), .reset_n(reset_n), .usb_d_p(usb_d_p), .usb_d_n(usb_d_n),
    .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pkt_start(rx_pkt_start),
    .rx_pkt_end(rx_pkt_end), .rx_err_stuff(rx_err_stuff), .rx_err_align(rx_err_align),
    .rx_err_crc(rx_err_crc), .rx_active(rx_active), .rx_byte_cnt(rx_byte_cnt)
  );

  assign outs = {rx_data, rx_valid, rx_pkt_start, rx_pkt_end, rx_err_stuff,
                 rx_err_align, rx_err_crc, rx_active, rx_byte_cnt};

  always #10 clk48_host = ~clk48_host;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [13:0] ev_end(input bit align, input bit crc);
    return {2'b00, 1'b1, 1'b0, align, crc, 8'h00};
  endfunction

  // Every strobe cycle must match the next queued expectation
  always @(negedge clk48_host) begin : mon
    logic [13:0] obs;
    obs = {rx_pkt_start, rx_valid, rx_pkt_end, rx_err_stuff, rx_err_align, rx_err_crc,
           rx_valid ? rx_data : 8'h00};
    if ((|obs[13:8]) === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_event", 32'(obs), 32'h0);
      else                   chk("event", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  task automatic put_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bq.push_back(b[i]);
  endtask

  task automatic add_crc16();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 8; i < bq.size(); i++) c = {c[14:0], 1'b0} ^ ((bq[i] ^ c[15]) ? 16'h8005 : 16'h0000);
    for (int i = 15; i >= 0; i--) bq.push_back(!c[i]);
  endtask

  task automatic add_crc5();
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 8; i < bq.size(); i++) c = {c[3:0], 1'b0} ^ ((bq[i] ^ c[4]) ? 5'h05 : 5'h00);
    for (int i = 4; i >= 0; i--) bq.push_back(!c[i]);
  endtask

  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = bq[8*k+i];
    return b;
  endfunction

  // NRZI-encode bq with bit stuffing (none from index raw_from on), add SYNC, EOP, idle
  task automatic encode(input int raw_from);
    logic [1:0] lvl;
    int ones;
    lq.delete();
    for (int i = 0; i < 8; i++) lq.push_back((i % 2 == 1 && i != 7) ? J : K);
    lvl = K;
    ones = 0;
    for (int i = 0; i < bq.size(); i++) begin
      if (bq[i]) ones++;
      else begin ones = 0; lvl = ~lvl; end
      lq.push_back(lvl);
      if (ones == 6 && i < raw_from) begin lvl = ~lvl; lq.push_back(lvl); ones = 0; end
    end
    lq.push_back(SE0);
    lq.push_back(SE0);
    for (int i = 0; i < 13; i++) lq.push_back(J);
  endtask

  task automatic drive(input int from, input int to, input bit jit);
    for (int i = from; i < to && i < lq.size(); i++) begin
      {usb_d_p, usb_d_n} = lq[i];
      repeat (jit ? JIT[i % 8] : 4) @(posedge clk48_host);
      #1;
    end
  endtask

  task automatic exp_bytes(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({6'b010000, byte_at(k)});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk48_host);
    #1;
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic build_t1();
    bq.delete();
    put_byte(8'hC3); put_byte(8'h01); put_byte(8'h02);
    add_crc16();
    encode(NOSTUFF_OFF);
  endtask

  task automatic expect_t1();
    exp_q.push_back(EV_START);
    exp_bytes(5);
    exp_q.push_back(ev_end(1'b0, 1'b0));
  endtask

  initial begin
    #5 reset_n = 1'b0;
    repeat (3) @(posedge clk48_host);
    #1;
    chk("reset_outputs", 32'(outs), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk48_host);
    #1;

    // Test 1: PID C3, 01 02, CRC16
    build_t1();
    expect_t1();
    drive(0, 20, 1'b0);
    chk("t1_active_mid", 32'(rx_active), 32'h1);
    drive(20, lq.size(), 1'b0);
    drain("t1");
    chk("t1_byte_cnt", 32'(rx_byte_cnt), 32'd5);
    chk("t1_active_end", 32'(rx_active), 32'h0);
    chk("t1_last_data", 32'(rx_data), 32'(byte_at(4)));

    // Test 2: DATA1 FF FF FF, stuffed on the wire
    bq.delete();
    put_byte(8'h4B); put_byte(8'hFF); put_byte(8'hFF); put_byte(8'hFF);
    add_crc16();
    encode(NOSTUFF_OFF);
    exp_q.push_back(EV_START);
    exp_bytes(6);
    exp_q.push_back(ev_end(1'b0, 1'b0));
    drive(0, lq.size(), 1'b0);
    drain("t2");
    chk("t2_byte_cnt", 32'(rx_byte_cnt), 32'd6);

    // Test 3: seven 1s unstuffed; violation lands on 8th bit of a byte
    bq.delete();
    put_byte(8'hC3);
    bq.push_back(1'b0);
    for (int i = 0; i < 7; i++) bq.push_back(1'b1);
    encode(8);
    exp_q.push_back(EV_START);
    exp_bytes(1);
    exp_q.push_back(EV_STUFF);
    drive(0, lq.size(), 1'b0);
    drain("t3");
    chk("t3_active", 32'(rx_active), 32'h0);
    chk("t3_byte_cnt", 32'(rx_byte_cnt), 32'd1);

    // Test 4: PID + 4 bits then EOP -> misaligned end
    bq.delete();
    put_byte(8'hC3);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1); bq.push_back(1'b0);
    encode(NOSTUFF_OFF);
    exp_q.push_back(EV_START);
    exp_bytes(1);
    exp_q.push_back(ev_end(1'b1, 1'b0));
    drive(0, lq.size(), 1'b0);
    drain("t4");
    chk("t4_byte_cnt", 32'(rx_byte_cnt), 32'd1);

    // Test 5: test 1 with +/-1 edge jitter and slow phase walk
    build_t1();
    expect_t1();
    drive(0, lq.size(), 1'b1);
    drain("t5");
    chk("t5_byte_cnt", 32'(rx_byte_cnt), 32'd5);

    // Test 6: reset after two bytes, then full packet again
    build_t1();
    exp_q.push_back(EV_START);
    exp_bytes(2);
    drive(0, 25, 1'b0);
    repeat (4) @(posedge clk48_host);
    drain("t6_pre");
    chk("t6_active_pre", 32'(rx_active), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 32'(outs), 32'h0);
    {usb_d_p, usb_d_n} = J;
    repeat (5) @(posedge clk48_host);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk48_host);
    #1;
    build_t1();
    expect_t1();
    drive(0, lq.size(), 1'b0);
    drain("t6");
    chk("t6_byte_cnt", 32'(rx_byte_cnt), 32'd5);

`ifdef USB_RX_MON_CRC_EN
    // Test 7: corrupted payload bit -> CRC error; IN token with good CRC5
    bq.delete();
    put_byte(8'hC3); put_byte(8'h01); put_byte(8'h02);
    add_crc16();
    bq[9] = !bq[9];
    encode(NOSTUFF_OFF);
    exp_q.push_back(EV_START);
    exp_bytes(5);
    exp_q.push_back(ev_end(1'b0, 1'b1));
    drive(0, lq.size(), 1'b0);
    drain("t7_crc16");
    bq.delete();
    put_byte(8'h69);
    for (int i = 0; i < 11; i++) bq.push_back(1'b0);
    add_crc5();
    encode(NOSTUFF_OFF);
    exp_q.push_back(EV_START);
    exp_bytes(3);
    exp_q.push_back(ev_end(1'b0, 1'b0));
    drive(0, lq.size(), 1'b0);
    drain("t7_crc5");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
